// File: rtl/sram_confreg.sv
// sram_confreg: responder on the core's data SRAM-like bus. It holds two scratch
// registers, a free-running timer with a compare interrupt, an LED register and a
// synchronised switch input. Read data comes back one cycle after the access edge.
module sram_confreg #(
  parameter logic [31:0] BASE_ADDR    = 32'hbfaf_0000,
  parameter logic        TIMER_RST_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [15:0] switch,
  output logic [15:0] led,
  output logic        timer_int
);

  localparam logic [2:0] IDX_SCRATCH0 = 3'd0;
  localparam logic [2:0] IDX_SCRATCH1 = 3'd1;
  localparam logic [2:0] IDX_TIMER    = 3'd2;
  localparam logic [2:0] IDX_LED      = 3'd3;
  localparam logic [2:0] IDX_SWITCH   = 3'd4;
  localparam logic [2:0] IDX_CMP      = 3'd5;
  localparam logic [2:0] IDX_IRQ      = 3'd6;
  localparam logic [2:0] IDX_CTRL     = 3'd7;

  logic [31:0] scratch0_q, scratch0_d;
  logic [31:0] scratch1_q, scratch1_d;
  logic [31:0] timer_q,    timer_d;
  logic [31:0] cmp_q,      cmp_d;
  logic [15:0] led_q,      led_d;
  logic [15:0] sw_q,       sw_d;
  logic        pend_q,     pend_d;
  logic        timer_en_q, timer_en_d;
  logic        irq_en_q,   irq_en_d;
  logic [31:0] rdata_q,    rdata_d;

  logic        hit;
  logic        wr;
  logic        rd;
  logic [2:0]  idx;
  logic [31:0] rd_val;
  logic [31:0] led_merged;
  logic        cmp_set;
  logic        pend_clr;

  // Byte-lane merge: lanes with their enable set take the new data.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

  // Address decode: the whole upper half must match and only 8 words are mapped.
  always_comb begin
    hit = data_sram_en
        && (data_sram_addr[31:16] == BASE_ADDR[31:16])
        && (data_sram_addr[15:5] == 11'd0);
    idx = data_sram_addr[4:2];
    wr  = hit && (data_sram_wen != 4'b0000);
    rd  = hit && (data_sram_wen == 4'b0000);
  end

  // Read mux over pre-update register values.
  always_comb begin
    rd_val = 32'd0;
    case (idx)
      IDX_SCRATCH0: rd_val = scratch0_q;
      IDX_SCRATCH1: rd_val = scratch1_q;
      IDX_TIMER:    rd_val = timer_q;
      IDX_LED:      rd_val = {16'd0, led_q};
      IDX_SWITCH:   rd_val = {16'd0, sw_q};
      IDX_CMP:      rd_val = cmp_q;
      IDX_IRQ:      rd_val = {31'd0, pend_q};
      IDX_CTRL:     rd_val = {30'd0, irq_en_q, timer_en_q};
      default:      rd_val = 32'd0;
    endcase
  end

  // Next-state logic for every register; writes override timer increment,
  // and a compare hit overrides a simultaneous pend clear.
  always_comb begin
    scratch0_d = scratch0_q;
    scratch1_d = scratch1_q;
    cmp_d      = cmp_q;
    led_d      = led_q;
    timer_en_d = timer_en_q;
    irq_en_d   = irq_en_q;
    sw_d       = switch;
    led_merged = merge_bytes({16'd0, led_q}, data_sram_wdata, {2'b00, data_sram_wen[1:0]});

    if (wr) begin
      case (idx)
        IDX_SCRATCH0: scratch0_d = merge_bytes(scratch0_q, data_sram_wdata, data_sram_wen);
        IDX_SCRATCH1: scratch1_d = merge_bytes(scratch1_q, data_sram_wdata, data_sram_wen);
        IDX_LED:      led_d      = led_merged[15:0];
        IDX_CMP:      cmp_d      = merge_bytes(cmp_q, data_sram_wdata, data_sram_wen);
        IDX_CTRL: begin
          if (data_sram_wen[0]) begin
            timer_en_d = data_sram_wdata[0];
            irq_en_d   = data_sram_wdata[1];
          end
        end
        default: ;
      endcase
    end

    if (wr && (idx == IDX_TIMER)) begin
      timer_d = merge_bytes(timer_q, data_sram_wdata, data_sram_wen);
    end else if (timer_en_q) begin
      timer_d = timer_q + 32'd1;
    end else begin
      timer_d = timer_q;
    end

    cmp_set  = timer_en_q && (timer_q == cmp_q);
    pend_clr = wr && (idx == IDX_IRQ) && data_sram_wen[0] && data_sram_wdata[0];
    pend_d   = cmp_set || (pend_q && !pend_clr);

    if (!data_sram_en) begin
      rdata_d = rdata_q;
    end else if (rd) begin
      rdata_d = rd_val;
    end else begin
      rdata_d = 32'd0;
    end
  end

  // State registers with synchronous reset that overrides any access.
  always_ff @(posedge clk) begin
    if (rst) begin
      scratch0_q <= 32'd0;
      scratch1_q <= 32'd0;
      timer_q    <= 32'd0;
      cmp_q      <= 32'd0;
      led_q      <= 16'd0;
      sw_q       <= 16'd0;
      pend_q     <= 1'b0;
      timer_en_q <= TIMER_RST_EN;
      irq_en_q   <= 1'b0;
      rdata_q    <= 32'd0;
    end else begin
      scratch0_q <= scratch0_d;
      scratch1_q <= scratch1_d;
      timer_q    <= timer_d;
      cmp_q      <= cmp_d;
      led_q      <= led_d;
      sw_q       <= sw_d;
      pend_q     <= pend_d;
      timer_en_q <= timer_en_d;
      irq_en_q   <= irq_en_d;
      rdata_q    <= rdata_d;
    end
  end

  assign data_sram_rdata = rdata_q;
  assign led             = led_q;
  assign timer_int       = pend_q & irq_en_q;

endmodule
